nibble_add_seq: RTL and testbench
=================================

// Module: nibble_add_seq
// PURPOSE
//  Sequencer that reuses one external 4-bit ripple adder (a,b,cin -> s,cout) to add
//  two NIBBLES*4-bit operands, one nibble per clock, LSB nibble first. Carry is
//  registered between nibbles. Sits between a requester (start/done handshake) and
//  the shared combinational 4-bit adder instance, which it drives exclusively.
// PARAMETERS
//  NIBBLES  4  operand width in nibbles (operand width W = 4*NIBBLES); legal >= 1
// PORTS
//  clk       in   1    clock, all logic on rising edge
//  rst       in   1    synchronous reset, active-high
//  start     in   1    request; sampled only in IDLE
//  op_a      in   W    operand A, captured on accepted start
//  op_b      in   W    operand B, captured on accepted start
//  cin_i     in   1    carry-in to nibble 0, captured on accepted start
//  add_a     out  4    to adder input a
//  add_b     out  4    to adder input b
//  add_cin   out  1    to adder carry-in
//  add_s     in   4    from adder sum (combinational, same cycle)
//  add_cout  in   1    from adder carry-out (combinational, same cycle)
//  busy      out  1    high in RUN and DONE
//  done      out  1    one-cycle pulse: sum/cout_o valid
//  sum       out  W    result, held until the next accepted start
//  cout_o    out  1    final carry-out, held with sum
// BEHAVIOUR
//  Reset (rst=1 at an edge, any state): state=IDLE, idx=0, carry reg=0, busy=0,
//   done=0, sum=0, cout_o=0, operand regs=0. Reset mid-RUN aborts; no done pulse.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: start=1 at an edge -> capture op_a, op_b, cin_i into regs, carry<=cin_i,
//   idx<=0, sum<=0, cout_o<=0, go RUN. start=0 -> stay.
//  RUN: add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry.
//   Each edge: sum[4*idx+:4]<=add_s, carry<=add_cout, idx<=idx+1.
//   At the edge with idx==NIBBLES-1: cout_o<=add_cout, go DONE.
//  DONE: done=1 for exactly this one cycle; next edge -> IDLE.
//  Outside RUN: add_a=0, add_b=0, add_cin=0.
//  Latency: start accepted at edge E0 -> done high in cycle after edge E0+NIBBLES,
//   i.e. NIBBLES+1 cycles from start edge; next start acceptable at E0+NIBBLES+2.
//  start while busy (RUN/DONE): ignored, no queuing; operand changes ignored too.
//  Arithmetic: {cout_o,sum} = op_a + op_b + cin_i, modulo 2^(W+1); unsigned.
//  Carry between nibbles only via registered carry; never combinational loop.
//  idx width = max(1,$clog2(NIBBLES)); NIBBLES=1 -> RUN lasts one cycle.
//  sum/cout_o change only on accepted start (cleared) and in RUN (filled).
// TESTING (NIBBLES=4 unless noted; bench includes the 4-bit adder model)
//  1. a=16'h1234, b=16'h4321, cin=0, start -> done 5 cycles later, sum=16'h5555, cout_o=0
//  2. a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout_o=1; add_cin=1 on nibbles 1..3
//  3. a=16'h0005, b=16'h0004, cin=1 -> sum=16'h000A, cout_o=0; then a=16'h8000,
//     b=16'h9000, cin=0 -> sum=16'h1000, cout_o=1; busy low exactly 1 cycle between
//  4. start pulsed again 2 cycles into case 1 with a=16'hFFFF -> ignored, result 16'h5555,
//     single done pulse
//  5. rst=1 at idx==2 of case 2 -> next cycle busy=0, done=0, sum=0, cout_o=0; no done
//  6. NIBBLES=1: a=4'd8, b=4'd9, cin=0 -> sum=4'd1, cout_o=1, done 2 cycles after start

Source files
------------

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: adds two NIBBLES*4-bit operands one nibble per clock using a
// shared external 4-bit combinational adder, LSB nibble first.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start                 request, sampled only while idle
//   op_a, op_b, cin_i     operands and carry-in, captured on accepted start
//   add_a, add_b, add_cin drive the shared adder (zero when not adding)
//   add_s, add_cout       adder results, same cycle
//   busy                  high while a request is in flight (RUN and DONE)
//   done                  one-cycle pulse when sum/cout_o are valid
//   sum, cout_o           result, held until the next accepted start
module nibble_add_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin_i,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout_o
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_cout;

    logic [IDX_W+1:0]   w_shift;
    logic [3:0]         w_nib_a;
    logic [3:0]         w_nib_b;
    logic               w_last;

    // Bit offset of the current nibble (idx*4)
    assign w_shift = {r_idx, 2'b00};
    assign w_nib_a = 4'(r_a >> w_shift);
    assign w_nib_b = 4'(r_b >> w_shift);
    assign w_last  = (r_idx == IDX_W'(NIBBLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and adder drive; adder inputs are quiet outside RUN
    always_comb begin
        w_state_nxt = r_state;
        add_a       = 4'd0;
        add_b       = 4'd0;
        add_cin     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                add_a   = w_nib_a;
                add_b   = w_nib_b;
                add_cin = r_carry;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture and nibble-serial accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_carry <= cin_i;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // sum was cleared on start, so OR-ing each nibble in place is exact
                    r_sum   <= r_sum | (W'(add_s) << w_shift);
                    r_carry <= add_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_cout <= add_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (r_state == S_RUN) || (r_state == S_DONE);
    assign done   = (r_state == S_DONE);
    assign sum    = r_sum;
    assign cout_o = r_cout;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Testbench for nibble_add_seq: a NIBBLES=4 and a NIBBLES=1 instance, each wired
// to a behavioural 4-bit adder, checked against plain integer arithmetic.
module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int n_done1 = 0;

    // NIBBLES=4 instance
    logic        start;
    logic [15:0] op_a, op_b;
    logic        cin_i;
    logic [3:0]  add_a, add_b, add_s;
    logic        add_cin, add_cout;
    logic        busy, done, cout_o;
    logic [15:0] sum;

    assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    nibble_add_seq #(.NIBBLES(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin_i(cin_i),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
        .busy(busy), .done(done), .sum(sum), .cout_o(cout_o)
    );

    // NIBBLES=1 instance
    logic        start1;
    logic [3:0]  op_a1, op_b1;
    logic        cin1;
    logic [3:0]  add_a1, add_b1, add_s1;
    logic        add_cin1, add_cout1;
    logic        busy1, done1, cout1;
    logic [3:0]  sum1;

    assign {add_cout1, add_s1} = 5'(add_a1) + 5'(add_b1) + 5'(add_cin1);

    nibble_add_seq #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1), .cin_i(cin1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_s(add_s1), .add_cout(add_cout1),
        .busy(busy1), .done(done1), .sum(sum1), .cout_o(cout1)
    );

    always @(negedge clk) begin
        if (done)  n_done  <= n_done + 1;
        if (done1) n_done1 <= n_done1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Carry entering nibble k of a+b+ci
    function automatic logic [31:0] carry_into(input logic [15:0] a, input logic [15:0] b,
                                               input logic ci, input int k);
        logic [31:0] m;
        m = (32'd1 << (4 * k)) - 32'd1;
        return ((32'(a) & m) + (32'(b) & m) + 32'(ci)) >> (4 * k);
    endfunction

    // One full request on the 4-nibble DUT; glitch_at >= 0 re-pulses start mid-run.
    // Returns one cycle after done, in IDLE, at the slot where a new start may be driven.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input int glitch_at);
        logic [16:0] full;
        int d0;
        full  = 17'(a) + 17'(b) + 17'(ci);
        d0    = n_done;
        start = 1'b1; op_a = a; op_b = b; cin_i = ci;
        @(posedge clk); #1;
        start = 1'b0;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
        cin_i = 1'($urandom);
        check("busy_run", busy, 1);
        check("sum_clr", sum, 0);
        for (int k = 0; k < 4; k++) begin
            check("add_a", add_a, (32'(a) >> (4 * k)) & 32'hF);
            check("add_b", add_b, (32'(b) >> (4 * k)) & 32'hF);
            check("add_cin", add_cin, carry_into(a, b, ci, k) & 32'h1);
            check("done_early", done, 0);
            if (k == glitch_at) begin
                start = 1'b1;
                op_a  = 16'hFFFF;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("done_pulse", done, 1);
        check("busy_done", busy, 1);
        check("sum", sum, 32'(full[15:0]));
        check("cout", cout_o, 32'(full[16]));
        @(posedge clk); #1;
        check("busy_idle", busy, 0);
        check("done_low", done, 0);
        check("sum_hold", sum, 32'(full[15:0]));
        check("cout_hold", cout_o, 32'(full[16]));
        check("add_idle", {add_cin, add_a, add_b}, 0);
        check("done_count", n_done - d0, 1);
    endtask

    initial begin
        int d0;
        logic [15:0] ra, rb;
        logic [4:0]  f1;

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin_i = 1'b0;
        start1 = 1'b0; op_a1 = '0; op_b1 = '0; cin1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout_o, 0);
        check("rst_add", {add_cin, add_a, add_b}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases; back-to-back calls leave busy low for exactly one cycle
        do_op(16'h1234, 16'h4321, 1'b0, -1);
        do_op(16'hFFFF, 16'h0001, 1'b0, -1);
        do_op(16'h0005, 16'h0004, 1'b1, -1);
        do_op(16'h8000, 16'h9000, 1'b0, -1);
        do_op(16'h1234, 16'h4321, 1'b0, 2);

        // Reset at idx==2 of FFFF+0001 aborts without a done pulse
        d0 = n_done;
        start = 1'b1; op_a = 16'hFFFF; op_b = 16'h0001; cin_i = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_cin", add_cin, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout_o, 0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_done", n_done - d0, 0);
        check("abort_idle", busy, 0);

        // Random requests against integer arithmetic
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 5 == 0) rb = ~ra;
            do_op(ra, rb, 1'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        // Single-nibble instance: RUN lasts one cycle, done 2 cycles after start
        for (int i = 0; i < 10; i++) begin
            logic [3:0] a1, b1;
            logic       c1;
            a1 = (i == 0) ? 4'd8 : 4'($urandom);
            b1 = (i == 0) ? 4'd9 : 4'($urandom);
            c1 = (i == 0) ? 1'b0 : 1'($urandom);
            f1 = 5'(a1) + 5'(b1) + 5'(c1);
            d0 = n_done1;
            start1 = 1'b1; op_a1 = a1; op_b1 = b1; cin1 = c1;
            @(posedge clk); #1;
            start1 = 1'b0;
            check("n1_busy", busy1, 1);
            check("n1_done_early", done1, 0);
            check("n1_add", {add_cin1, add_a1, add_b1}, {23'd0, c1, a1, b1});
            @(posedge clk); #1;
            check("n1_done", done1, 1);
            check("n1_sum", sum1, 32'(f1[3:0]));
            check("n1_cout", cout1, 32'(f1[4]));
            @(posedge clk); #1;
            check("n1_idle", busy1, 0);
            check("n1_done_count", n_done1 - d0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
